// File: rtl/truth_table_sweeper.sv
// Sweeps an N-input function pair through every minterm, capturing both truth tables and their mismatch.
// Optional early stop on first mismatch: define TRUTH_TABLE_SWEEPER_STOP_ON_MISMATCH_EN.
module truth_table_sweeper #(
    parameter int N      = 2,
    parameter int SETTLE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic [N-1:0]        x_out,
    input  logic                sa,
    input  logic                sb,
    output logic                busy,
    output logic                done,
    output logic [(1<<N)-1:0]   table_a,
    output logic [(1<<N)-1:0]   table_b,
    output logic [(1<<N)-1:0]   mismatch,
    output logic [N:0]          err_count,
    output logic                equal
);

    localparam int TW = 1 << N;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);
    localparam logic [N-1:0]  X_LAST   = N'(TW - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          diff;
    logic          last;
    logic          finish;
    logic [N:0]    err_next;

    // equal must reflect the count including the final sample, so it uses err_next.
    always_comb begin
        diff     = sa ^ sb;
        last     = (x_out == X_LAST);
        err_next = err_count + {{N{1'b0}}, diff};
`ifdef TRUTH_TABLE_SWEEPER_STOP_ON_MISMATCH_EN
        finish   = last | diff;
`else
        finish   = last;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            x_out     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_a   <= '0;
            table_b   <= '0;
            mismatch  <= '0;
            err_count <= '0;
            equal     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        table_a   <= '0;
                        table_b   <= '0;
                        mismatch  <= '0;
                        err_count <= '0;
                        equal     <= 1'b0;
                        x_out     <= '0;
                        cnt       <= CNT_LOAD;
                        busy      <= 1'b1;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        table_a[x_out]  <= sa;
                        table_b[x_out]  <= sb;
                        mismatch[x_out] <= diff;
                        err_count       <= err_next;
                        if (finish) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            x_out <= '0;
                            equal <= (err_next == '0);
                        end else begin
                            x_out <= x_out + N'(1);
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    x_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: SETTLE=1 and SETTLE=3 instances, A = a'.b against B = a'.b or ~(a&~b).
module tb_truth_table_sweeper;

    logic       clk;
    logic       reset;
    logic       mode;
    logic       start0, start1;
    logic [1:0] x0, x1;
    logic       sa0, sb0, sa1, sb1;
    logic       busy0, busy1, done0, done1;
    logic [3:0] ta0, tb0, mm0, ta1, tb1, mm1;
    logic [2:0] ec0, ec1;
    logic       eq0, eq1;

    int errors = 0;
    int checks = 0;

    // a = x[1], b = x[0]; mode selects the second implementation's function
    assign sa0 = ~x0[1] & x0[0];
    assign sb0 = mode ? ~(x0[1] & ~x0[0]) : (~x0[1] & x0[0]);
    assign sa1 = ~x1[1] & x1[0];
    assign sb1 = mode ? ~(x1[1] & ~x1[0]) : (~x1[1] & x1[0]);

    truth_table_sweeper #(.N(2), .SETTLE(1)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .x_out(x0), .sa(sa0), .sb(sb0),
        .busy(busy0), .done(done0), .table_a(ta0), .table_b(tb0), .mismatch(mm0),
        .err_count(ec0), .equal(eq0)
    );

    truth_table_sweeper #(.N(2), .SETTLE(3)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .x_out(x1), .sa(sa1), .sb(sb1),
        .busy(busy1), .done(done1), .table_a(ta1), .table_b(tb1), .mismatch(mm1),
        .err_count(ec1), .equal(eq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef TRUTH_TABLE_SWEEPER_STOP_ON_MISMATCH_EN
    localparam int          D_LEN = 1;
    localparam logic [3:0]  D_TA  = 4'b0000;
    localparam logic [3:0]  D_TB  = 4'b0001;
    localparam logic [3:0]  D_MM  = 4'b0001;
    localparam logic [2:0]  D_EC  = 3'd1;
`else
    localparam int          D_LEN = 4;
    localparam logic [3:0]  D_TA  = 4'b0010;
    localparam logic [3:0]  D_TB  = 4'b1011;
    localparam logic [3:0]  D_MM  = 4'b1001;
    localparam logic [2:0]  D_EC  = 3'd2;
`endif

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero0(input string tag);
        check({tag, " x0"},    32'(x0),    32'd0);
        check({tag, " busy0"}, 32'(busy0), 32'd0);
        check({tag, " done0"}, 32'(done0), 32'd0);
        check({tag, " ta0"},   32'(ta0),   32'd0);
        check({tag, " tb0"},   32'(tb0),   32'd0);
        check({tag, " mm0"},   32'(mm0),   32'd0);
        check({tag, " ec0"},   32'(ec0),   32'd0);
        check({tag, " eq0"},   32'(eq0),   32'd0);
    endtask

    task automatic sweep0(input logic m, input int len, input logic [3:0] ta, input logic [3:0] tb,
                          input logic [3:0] mm, input logic [2:0] ec, input logic eq);
        mode   = m;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 0; k < len; k++) begin
            check("run x0",    32'(x0),    32'(k));
            check("run busy0", 32'(busy0), 32'd1);
            check("run done0", 32'(done0), 32'd0);
            tick();
        end
        check("end done0", 32'(done0), 32'd1);
        check("end busy0", 32'(busy0), 32'd0);
        check("end x0",    32'(x0),    32'd0);
        check("ta0",       32'(ta0),   32'(ta));
        check("tb0",       32'(tb0),   32'(tb));
        check("mm0",       32'(mm0),   32'(mm));
        check("ec0",       32'(ec0),   32'(ec));
        check("eq0",       32'(eq0),   32'(eq));
        tick();
        check("idle done0", 32'(done0), 32'd0);
        check("hold ta0",   32'(ta0),   32'(ta));
        check("hold eq0",   32'(eq0),   32'(eq));
    endtask

    initial begin
        reset  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        mode   = 1'b0;
        tick();
        check("rst done0", 32'(done0), 32'd0);
        tick();
        check_zero0("rst");
        check("rst x1",    32'(x1),    32'd0);
        check("rst busy1", 32'(busy1), 32'd0);
        check("rst ec1",   32'(ec1),   32'd0);
        reset = 1'b0;
        tick();

        // identical units, then a'.b vs ~(a&~b)
        sweep0(1'b0, 4, 4'b0010, 4'b0010, 4'b0000, 3'd0, 1'b1);
        sweep0(1'b1, D_LEN, D_TA, D_TB, D_MM, D_EC, 1'b0);

        // SETTLE=3: each minterm held three cycles
        mode   = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < D_LEN; k++) begin
            for (int s = 0; s < 3; s++) begin
                check("s3 x1",    32'(x1),    32'(k));
                check("s3 busy1", 32'(busy1), 32'd1);
                check("s3 done1", 32'(done1), 32'd0);
                tick();
            end
        end
        check("s3 done1 end", 32'(done1), 32'd1);
        check("s3 ta1",       32'(ta1),   32'(D_TA));
        check("s3 tb1",       32'(tb1),   32'(D_TB));
        check("s3 mm1",       32'(mm1),   32'(D_MM));
        check("s3 ec1",       32'(ec1),   32'(D_EC));
        check("s3 eq1",       32'(eq1),   32'd0);
        tick();
        check("s3 idle done1", 32'(done1), 32'd0);

        // start held high: no mid-sweep restart, relaunch one cycle after done
        mode   = 1'b0;
        start0 = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("hold x0",    32'(x0),    32'(k));
            check("hold busy0", 32'(busy0), 32'd1);
            tick();
        end
        check("hold done0", 32'(done0), 32'd1);
        tick();
        check("hold idle busy0", 32'(busy0), 32'd0);
        check("hold idle done0", 32'(done0), 32'd0);
        check("hold idle eq0",   32'(eq0),   32'd1);
        tick();
        check("relaunch busy0", 32'(busy0), 32'd1);
        check("relaunch x0",    32'(x0),    32'd0);
        check("relaunch eq0",   32'(eq0),   32'd0);
        tick();
        check("run2 x0", 32'(x0), 32'd1);

        // reset mid-sweep aborts with no done pulse
        reset  = 1'b1;
        start0 = 1'b0;
        tick();
        check_zero0("abort");
        tick();
        check("abort done0 b", 32'(done0), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("post abort done0", 32'(done0), 32'd0);
            check("post abort busy0", 32'(busy0), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
